// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the TSC pipeline control: forwarding codes, halt FSM
// states and the per-stage control record carried ID->EX->MEM->WB.
package pipe_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      FWD_NONE = 2'd0,
      FWD_EX   = 2'd1,
      FWD_MEM  = 2'd2,
      FWD_WB   = 2'd3
   } fwd_sel_e;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } halt_state_e;

   // Destination index is held beside this record since its width is a module parameter.
   typedef struct packed {
      logic valid;
      logic regWrite;
      logic memRead;
      logic memWrite;
      logic portWrite;
      logic halt;
   } stage_ctrl_t;

   localparam stage_ctrl_t STAGE_EMPTY = '0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decoder/datapath <-> pipeline-control signal bundle.
// master: decoder and datapath side; slave: pipe_hazard_ctrl.
interface pipe_hazard_ctrl_if #(
   parameter int unsigned REG_AW = 2,
   parameter int unsigned CNT_W  = 16
);
   logic              id_valid;
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic              id_uses_rs;
   logic              id_uses_rt;
   logic [REG_AW-1:0] id_dst;
   logic              id_reg_write;
   logic              id_mem_read;
   logic              id_mem_write;
   logic              id_port_write;
   logic              id_halt;
   logic              id_redirect;
   logic              icache_stall;
   logic              dcache_stall;

   logic              pc_write;
   logic              ifid_write;
   logic              ifid_flush;
   logic              d_readM;
   logic              d_writeM;
   logic              wb_reg_write;
   logic              wb_port_write;
   logic [REG_AW-1:0] wb_dst;
   logic [1:0]        fwd_rs_sel;
   logic [1:0]        fwd_rt_sel;
   logic [CNT_W-1:0]  num_inst;
   logic              is_halted;

   modport master (
      output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dst,
             id_reg_write, id_mem_read, id_mem_write, id_port_write,
             id_halt, id_redirect, icache_stall, dcache_stall,
      input  pc_write, ifid_write, ifid_flush, d_readM, d_writeM,
             wb_reg_write, wb_port_write, wb_dst, fwd_rs_sel, fwd_rt_sel,
             num_inst, is_halted
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dst,
             id_reg_write, id_mem_read, id_mem_write, id_port_write,
             id_halt, id_redirect, icache_stall, dcache_stall,
      output pc_write, ifid_write, ifid_flush, d_readM, d_writeM,
             wb_reg_write, wb_port_write, wb_dst, fwd_rs_sel, fwd_rt_sel,
             num_inst, is_halted
   );
endinterface

// File: rtl/pipe_hazard_ctrl_fwd.sv
// Operand forwarding select for one source register; youngest producing stage wins.
module pipe_fwd_sel
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int unsigned REG_AW = 2,
   parameter int          WB_FWD = 1
) (
   input  logic [REG_AW-1:0] src,
   input  logic              uses,
   input  logic              exWr,
   input  logic [REG_AW-1:0] exDst,
   input  logic              memWr,
   input  logic [REG_AW-1:0] memDst,
   input  logic              wbWr,
   input  logic [REG_AW-1:0] wbDst,
   output fwd_sel_e          sel
);
   always_comb begin
      sel = FWD_NONE;
      if (uses) begin
         if (exWr && (exDst == src))
            sel = FWD_EX;
         else if (memWr && (memDst == src))
            sel = FWD_MEM;
         else if ((WB_FWD != 0) && wbWr && (wbDst == src))
            sel = FWD_WB;
      end
   end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage TSC pipeline control: stage control registers, stall/squash priority,
// forwarding selects, halt drain FSM and saturating retired-instruction counter.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int unsigned REG_AW = 2,
   parameter int unsigned CNT_W  = 16,
   parameter int          WB_FWD = 1
) (
   input  logic               Clk,
   input  logic               Reset,
   pipe_hazard_ctrl_if.slave  bus
);
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   stage_ctrl_t       exCtrl, memCtrl, wbCtrl, exNext;
   logic [REG_AW-1:0] exDst, memDst, wbDst;
   halt_state_e       state, stateNext;
   logic [CNT_W-1:0]  numInst;
   logic              rsHit, rtHit, loadUse, issue;
   fwd_sel_e          rsSel, rtSel;

   assign rsHit   = bus.id_uses_rs && (bus.id_rs == exDst);
   assign rtHit   = bus.id_uses_rt && (bus.id_rt == exDst);
   assign loadUse = exCtrl.valid && exCtrl.memRead && bus.id_valid && (rsHit || rtHit);

   // Stall priority: dcache > load-use > halt drain > icache > redirect > normal.
   always_comb begin
      bus.pc_write   = 1'b1;
      bus.ifid_write = 1'b1;
      bus.ifid_flush = 1'b0;
      issue          = bus.id_valid;
      stateNext      = state;
      if (bus.dcache_stall) begin
         bus.pc_write   = 1'b0;
         bus.ifid_write = 1'b0;
         issue          = 1'b0;
      end else if (loadUse) begin
         bus.pc_write   = 1'b0;
         bus.ifid_write = 1'b0;
         issue          = 1'b0;
      end else if (state != ST_RUN) begin
         bus.pc_write   = 1'b0;
         bus.ifid_flush = 1'b1;
         issue          = 1'b0;
      end else if (bus.icache_stall) begin
         bus.pc_write   = 1'b0;
         bus.ifid_flush = 1'b1;
      end else if (bus.id_valid && bus.id_redirect) begin
         bus.ifid_flush = 1'b1;
      end

      if (!bus.dcache_stall) begin
         case (state)
            ST_RUN:    if (issue && bus.id_halt) stateNext = ST_DRAIN;
            ST_DRAIN:  if (wbCtrl.valid && wbCtrl.halt) stateNext = ST_HALTED;
            ST_HALTED: stateNext = ST_HALTED;
            default:   stateNext = ST_RUN;
         endcase
      end
   end

   always_comb begin
      exNext = STAGE_EMPTY;
      if (issue) begin
         exNext.valid     = 1'b1;
         exNext.regWrite  = bus.id_reg_write;
         exNext.memRead   = bus.id_mem_read;
         exNext.memWrite  = bus.id_mem_write;
         exNext.portWrite = bus.id_port_write;
         exNext.halt      = bus.id_halt;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         exCtrl  <= STAGE_EMPTY;
         memCtrl <= STAGE_EMPTY;
         wbCtrl  <= STAGE_EMPTY;
         exDst   <= '0;
         memDst  <= '0;
         wbDst   <= '0;
      end else if (!bus.dcache_stall) begin
         exCtrl  <= exNext;
         exDst   <= bus.id_dst;
         memCtrl <= exCtrl;
         memDst  <= exDst;
         wbCtrl  <= memCtrl;
         wbDst   <= memDst;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)
         state <= ST_RUN;
      else
         state <= stateNext;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)
         numInst <= '0;
      else if (wbCtrl.valid && !bus.dcache_stall && (numInst != '1))
         numInst <= numInst + CNT_ONE;
   end

   pipe_fwd_sel #(.REG_AW(REG_AW), .WB_FWD(WB_FWD)) uFwdRs (
      .src    (bus.id_rs),
      .uses   (bus.id_uses_rs),
      .exWr   (exCtrl.valid && exCtrl.regWrite),
      .exDst  (exDst),
      .memWr  (memCtrl.valid && memCtrl.regWrite),
      .memDst (memDst),
      .wbWr   (wbCtrl.valid && wbCtrl.regWrite),
      .wbDst  (wbDst),
      .sel    (rsSel)
   );

   pipe_fwd_sel #(.REG_AW(REG_AW), .WB_FWD(WB_FWD)) uFwdRt (
      .src    (bus.id_rt),
      .uses   (bus.id_uses_rt),
      .exWr   (exCtrl.valid && exCtrl.regWrite),
      .exDst  (exDst),
      .memWr  (memCtrl.valid && memCtrl.regWrite),
      .memDst (memDst),
      .wbWr   (wbCtrl.valid && wbCtrl.regWrite),
      .wbDst  (wbDst),
      .sel    (rtSel)
   );

   assign bus.fwd_rs_sel    = rsSel;
   assign bus.fwd_rt_sel    = rtSel;
   assign bus.d_readM       = memCtrl.valid && memCtrl.memRead;
   assign bus.d_writeM      = memCtrl.valid && memCtrl.memWrite;
   // Held WB instruction must not write again while the pipe is frozen.
   assign bus.wb_reg_write  = wbCtrl.valid && wbCtrl.regWrite && !bus.dcache_stall;
   assign bus.wb_port_write = wbCtrl.valid && wbCtrl.portWrite && !bus.dcache_stall;
   assign bus.wb_dst        = wbDst;
   assign bus.num_inst      = numInst;
   assign bus.is_halted     = (state == ST_HALTED);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: dutA (WB_FWD=1, CNT_W=16) and dutB
// (WB_FWD=0, CNT_W=3) see the same instruction stream.
module tb_pipe_hazard_ctrl;
   logic        Clk = 1'b0;
   logic        Reset;
   int unsigned checks   = 0;
   int unsigned failures = 0;

   always #5 Clk = ~Clk;

   pipe_hazard_ctrl_if #(.REG_AW(2), .CNT_W(16)) busA ();
   pipe_hazard_ctrl_if #(.REG_AW(2), .CNT_W(3))  busB ();

   assign busB.id_valid      = busA.id_valid;
   assign busB.id_rs         = busA.id_rs;
   assign busB.id_rt         = busA.id_rt;
   assign busB.id_uses_rs    = busA.id_uses_rs;
   assign busB.id_uses_rt    = busA.id_uses_rt;
   assign busB.id_dst        = busA.id_dst;
   assign busB.id_reg_write  = busA.id_reg_write;
   assign busB.id_mem_read   = busA.id_mem_read;
   assign busB.id_mem_write  = busA.id_mem_write;
   assign busB.id_port_write = busA.id_port_write;
   assign busB.id_halt       = busA.id_halt;
   assign busB.id_redirect   = busA.id_redirect;
   assign busB.icache_stall  = busA.icache_stall;
   assign busB.dcache_stall  = busA.dcache_stall;

   pipe_hazard_ctrl #(.REG_AW(2), .CNT_W(16), .WB_FWD(1)) dutA (
      .Clk(Clk), .Reset(Reset), .bus(busA)
   );
   pipe_hazard_ctrl #(.REG_AW(2), .CNT_W(3), .WB_FWD(0)) dutB (
      .Clk(Clk), .Reset(Reset), .bus(busB)
   );

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic setId(input logic v, input logic [1:0] dst, input logic rw,
                        input logic [1:0] rs, input logic urs,
                        input logic [1:0] rt, input logic urt,
                        input logic mr, input logic mw, input logic hlt, input logic redir);
      busA.id_valid      = v;
      busA.id_dst        = dst;
      busA.id_reg_write  = rw;
      busA.id_rs         = rs;
      busA.id_uses_rs    = urs;
      busA.id_rt         = rt;
      busA.id_uses_rt    = urt;
      busA.id_mem_read   = mr;
      busA.id_mem_write  = mw;
      busA.id_port_write = 1'b0;
      busA.id_halt       = hlt;
      busA.id_redirect   = redir;
   endtask

   task automatic nop();
      setId(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask
   task automatic alu(input logic [1:0] dst, input logic [1:0] rs, input logic urs,
                      input logic [1:0] rt, input logic urt);
      setId(1'b1, dst, 1'b1, rs, urs, rt, urt, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask
   task automatic load(input logic [1:0] dst, input logic [1:0] rs);
      setId(1'b1, dst, 1'b1, rs, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask
   task automatic store(input logic [1:0] rs, input logic [1:0] rt);
      setId(1'b1, 2'd0, 1'b0, rs, 1'b1, rt, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
   endtask
   task automatic halt();
      setId(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask
   task automatic branch();
      setId(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      nop();
      busA.icache_stall = 1'b0;
      busA.dcache_stall = 1'b0;
      Reset = 1'b1;
      step();
      step();
      checkVal("rst_num_inst", busA.num_inst, 0);
      checkVal("rst_is_halted", busA.is_halted, 0);
      checkVal("rst_wb_reg_write", busA.wb_reg_write, 0);
      checkVal("rst_d_readM", busA.d_readM, 0);
      checkVal("rst_d_writeM", busA.d_writeM, 0);
      Reset = 1'b0;

      // load r1, then dependent add: one bubble, then MEM forwarding
      load(2'd1, 2'd0); #1;
      checkVal("ld_pc_write", busA.pc_write, 1);
      step();
      alu(2'd2, 2'd1, 1'b1, 2'd1, 1'b1); #1;
      checkVal("lu_pc_write", busA.pc_write, 0);
      checkVal("lu_ifid_write", busA.ifid_write, 0);
      checkVal("lu_fwd_rs", busA.fwd_rs_sel, 1);
      step();
      #1;
      checkVal("lu_resume_pc_write", busA.pc_write, 1);
      checkVal("lu_fwd_rs_mem", busA.fwd_rs_sel, 2);
      checkVal("lu_fwd_rt_mem", busA.fwd_rt_sel, 2);
      checkVal("lu_d_readM", busA.d_readM, 1);
      step();
      load(2'd1, 2'd0); #1;
      checkVal("ld_wb_reg_write", busA.wb_reg_write, 1);
      checkVal("ld_wb_dst", busA.wb_dst, 1);
      checkVal("num_inst_c4", busA.num_inst, 0);
      step();
      alu(2'd0, 2'd3, 1'b1, 2'd0, 1'b0); #1;
      checkVal("nodep_pc_write", busA.pc_write, 1);
      checkVal("nodep_fwd_rs", busA.fwd_rs_sel, 0);
      checkVal("num_inst_c5", busA.num_inst, 1);
      step();

      // ALU chain r1 <- ; r2 <- r1 ; r3 <- r1 ; r0 <- r1
      alu(2'd1, 2'd0, 1'b0, 2'd0, 1'b0); #1;
      checkVal("add_wb_dst", busA.wb_dst, 2);
      checkVal("add_wb_reg_write", busA.wb_reg_write, 1);
      step();
      alu(2'd2, 2'd1, 1'b1, 2'd0, 1'b0); #1;
      checkVal("chain_fwd_ex", busA.fwd_rs_sel, 1);
      checkVal("num_inst_c7", busA.num_inst, 2);
      step();
      alu(2'd3, 2'd1, 1'b1, 2'd0, 1'b0); #1;
      checkVal("chain_fwd_mem", busA.fwd_rs_sel, 2);
      step();
      alu(2'd0, 2'd1, 1'b1, 2'd1, 1'b0); #1;
      checkVal("chain_fwd_wb_on", busA.fwd_rs_sel, 3);
      checkVal("chain_fwd_wb_off", busB.fwd_rs_sel, 0);
      checkVal("chain_rt_unused", busA.fwd_rt_sel, 0);
      checkVal("num_inst_c9", busA.num_inst, 4);
      step();
      store(2'd0, 2'd3); #1;
      checkVal("st_fwd_rs", busA.fwd_rs_sel, 1);
      checkVal("st_fwd_rt", busA.fwd_rt_sel, 2);
      step();
      nop(); #1;
      checkVal("num_inst_c11", busA.num_inst, 6);
      step();

      // dcache stall held 4 cycles with the store in MEM
      busA.dcache_stall = 1'b1; #1;
      checkVal("ds_d_writeM", busA.d_writeM, 1);
      checkVal("ds_wb_masked", busA.wb_reg_write, 0);
      checkVal("ds_pc_write", busA.pc_write, 0);
      checkVal("ds_ifid_write", busA.ifid_write, 0);
      checkVal("ds_ifid_flush", busA.ifid_flush, 0);
      checkVal("ds_num_inst", busA.num_inst, 7);
      step();
      for (int i = 0; i < 3; i++) begin
         #1;
         checkVal("ds_hold_d_writeM", busA.d_writeM, 1);
         checkVal("ds_hold_num_inst", busA.num_inst, 7);
         checkVal("ds_hold_wb_masked", busA.wb_reg_write, 0);
         step();
      end
      busA.dcache_stall = 1'b0; #1;
      checkVal("ds_rel_d_writeM", busA.d_writeM, 1);
      checkVal("ds_rel_wb_reg_write", busA.wb_reg_write, 1);
      checkVal("ds_rel_wb_dst", busA.wb_dst, 0);
      checkVal("ds_rel_num_inst", busA.num_inst, 7);
      step();
      #1;
      checkVal("st_done_d_writeM", busA.d_writeM, 0);
      checkVal("st_wb_no_write", busA.wb_reg_write, 0);
      checkVal("num_inst_c17", busA.num_inst, 8);
      checkVal("sat_b_c17", busB.num_inst, 7);
      step();

      // taken branch, then branch with concurrent icache stall
      branch(); #1;
      checkVal("br_pc_write", busA.pc_write, 1);
      checkVal("br_ifid_flush", busA.ifid_flush, 1);
      checkVal("num_inst_c18", busA.num_inst, 9);
      checkVal("sat_b_c18", busB.num_inst, 7);
      step();
      busA.icache_stall = 1'b1; #1;
      checkVal("br_ic_pc_write", busA.pc_write, 0);
      checkVal("br_ic_ifid_flush", busA.ifid_flush, 1);
      step();
      nop(); #1;
      checkVal("ic_pc_write", busA.pc_write, 0);
      checkVal("ic_ifid_flush", busA.ifid_flush, 1);
      step();
      busA.icache_stall = 1'b0; #1;
      checkVal("norm_pc_write", busA.pc_write, 1);
      checkVal("norm_ifid_flush", busA.ifid_flush, 0);
      step();

      // five instructions then HLT
      Reset = 1'b1; #1;
      checkVal("rst2_num_inst", busA.num_inst, 0);
      step();
      Reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         alu(2'(i), 2'd0, 1'b0, 2'd0, 1'b0); #1;
         checkVal("h_issue_pc_write", busA.pc_write, 1);
         step();
      end
      halt(); #1;
      checkVal("h_id_pc_write", busA.pc_write, 1);
      step();
      alu(2'd2, 2'd0, 1'b0, 2'd0, 1'b0); #1;
      checkVal("drain_pc_write", busA.pc_write, 0);
      checkVal("drain_ifid_flush", busA.ifid_flush, 1);
      checkVal("drain_is_halted", busA.is_halted, 0);
      step();
      #1;
      checkVal("drain2_pc_write", busA.pc_write, 0);
      step();
      #1;
      checkVal("hwb_is_halted", busA.is_halted, 0);
      checkVal("hwb_num_inst", busA.num_inst, 5);
      step();
      #1;
      checkVal("halted_is_halted", busA.is_halted, 1);
      checkVal("halted_num_inst", busA.num_inst, 6);
      checkVal("halted_no_issue", busA.wb_reg_write, 0);
      step();
      #1;
      checkVal("halted_sticky", busA.is_halted, 1);
      checkVal("halted_pc_write", busA.pc_write, 0);
      checkVal("halted_num_hold", busA.num_inst, 6);
      checkVal("halted_b_num", busB.num_inst, 6);
      step();

      // Reset while draining
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      halt(); #1;
      step();
      alu(2'd1, 2'd0, 1'b0, 2'd0, 1'b0); #1;
      checkVal("rd_drain_pc_write", busA.pc_write, 0);
      Reset = 1'b1; #1;
      checkVal("rd_run_pc_write", busA.pc_write, 1);
      checkVal("rd_is_halted", busA.is_halted, 0);
      checkVal("rd_num_inst", busA.num_inst, 0);
      step();
      Reset = 1'b0; #1;
      checkVal("rd_after_flush", busA.ifid_flush, 0);
      step();
      nop();
      for (int i = 0; i < 4; i++) step();
      #1;
      checkVal("rd_never_halts", busA.is_halted, 0);
      checkVal("rd_pc_write", busA.pc_write, 1);
      checkVal("rd_num_inst_end", busA.num_inst, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
